// File: rtl/create_d_pkg.sv
// Shared constants and FSM encoding for the RSA key helpers (create_d, create_e).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package create_d_pkg;

  localparam int WIDTH     = 64;  // operand width (E, L, D, r values)
  localparam int TWIDTH    = 65;  // two's-complement Bezout coefficient width
  localparam int DIV_STEPS = 64;  // one quotient bit per step, MSB first

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DIV,
    UPDATE,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/create_d_divmul.sv
// divmul64: 64-cycle restoring divider that also accumulates quotient*mult.
// Latency: the step on the start_n edge yields quotient bit 63; ready_n drops 63 cycles later.
// Backpressure: none; start_n low restarts at any time, results hold until the next start.
// Ports: clk, rst_n (sync, active-low), start_n (active-low load+first step),
//        dividend/divisor/mult operands, quotient/remainder/product results, ready_n (0 = results valid).
module divmul64
  import create_d_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_n,
  input  logic [WIDTH-1:0]  dividend,
  input  logic [WIDTH-1:0]  divisor,
  input  logic [TWIDTH-1:0] mult,
  output logic [WIDTH-1:0]  quotient,
  output logic [WIDTH-1:0]  remainder,
  output logic [TWIDTH-1:0] product,
  output logic              ready_n
);

  logic [WIDTH-1:0]  quo_q, quo_d, rem_q, rem_d, div_q, div_d;
  logic [TWIDTH-1:0] mult_q, mult_d, prod_q, prod_d;
  logic [6:0]        cnt_q, cnt_d;
  logic              busy_q, busy_d, ready_n_q, ready_n_d;

  logic [WIDTH-1:0]  src_quo, src_rem, src_div, step_quo, step_rem;
  logic [TWIDTH-1:0] src_mult, src_prod, step_prod;
  logic [WIDTH:0]    rem_sh, rem_sub;
  logic              qbit;

  always_comb begin
    // The start cycle performs the first step straight from the operand inputs,
    // so all 64 steps fit inside the caller's 64-cycle divide window.
    src_quo  = start_n ? quo_q  : dividend;
    src_rem  = start_n ? rem_q  : '0;
    src_div  = start_n ? div_q  : divisor;
    src_mult = start_n ? mult_q : mult;
    src_prod = start_n ? prod_q : '0;

    rem_sh  = {src_rem, src_quo[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, src_div};
    // rem_sh < 2*divisor, so bit WIDTH of the difference is set only on borrow.
    qbit    = ~rem_sub[WIDTH];

    step_rem  = qbit ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    step_quo  = {src_quo[WIDTH-2:0], qbit};
    step_prod = (src_prod << 1) + (qbit ? src_mult : '0);

    quo_d     = quo_q;
    rem_d     = rem_q;
    div_d     = div_q;
    mult_d    = mult_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    ready_n_d = ready_n_q;

    if (!start_n) begin
      quo_d     = step_quo;
      rem_d     = step_rem;
      div_d     = divisor;
      mult_d    = mult;
      prod_d    = step_prod;
      cnt_d     = 7'd1;
      busy_d    = ON;
      ready_n_d = 1'b1;
    end else if (busy_q) begin
      quo_d  = step_quo;
      rem_d  = step_rem;
      prod_d = step_prod;
      cnt_d  = cnt_q + 7'd1;
      if (cnt_q == 7'(DIV_STEPS - 1)) begin
        busy_d    = OFF;
        ready_n_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quo_q     <= '0;
      rem_q     <= '0;
      div_q     <= '0;
      mult_q    <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
      busy_q    <= OFF;
      ready_n_q <= 1'b1;
    end else begin
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      div_q     <= div_d;
      mult_q    <= mult_d;
      prod_q    <= prod_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      ready_n_q <= ready_n_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign product   = prod_q;
  assign ready_n   = ready_n_q;

endmodule

// File: rtl/create_d.sv
// create_d: RSA private exponent D = E^-1 mod L by extended Euclid.
// Latency: 1 (LOAD) + 65 per Euclid iteration + 1 (FIX), then ready_n drops on DONE entry.
// Backpressure: none; start_n low in any state aborts and restarts with fresh E/L.
// Ports: clk, rst_n (sync, active-low), start_n (active-low start/restart),
//        E (public exponent), L ((p-1)(q-1)), D (result), err (no inverse), ready_n (0 = D/err valid).
module create_d
  import create_d_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_n,
  input  logic [WIDTH-1:0] E,
  input  logic [WIDTH-1:0] L,
  output logic [WIDTH-1:0] D,
  output logic             err,
  output logic             ready_n
);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  e_q, e_d, l_q, l_d, r0_q, r0_d, r1_q, r1_d, d_q, d_d;
  logic [TWIDTH-1:0] t0_q, t0_d, t1_q, t1_d;
  logic              frc_q, frc_d, err_q, err_d, ready_n_q, ready_n_d;

  logic              div_start_n, div_ready_n;
  logic [WIDTH-1:0]  div_a, div_b, div_rem, div_quo_unused;
  logic [TWIDTH-1:0] div_m, div_prod, t_new;
  logic [WIDTH-1:0]  d_fix;

  // The quotient itself is not needed here: the product output already carries q*t1.
  divmul64 u_divmul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_n   (div_start_n),
    .dividend  (div_a),
    .divisor   (div_b),
    .mult      (div_m),
    .quotient  (div_quo_unused),
    .remainder (div_rem),
    .product   (div_prod),
    .ready_n   (div_ready_n)
  );

  always_comb begin
    state_d   = state_q;
    e_d       = e_q;
    l_d       = l_q;
    r0_d      = r0_q;
    r1_d      = r1_q;
    t0_d      = t0_q;
    t1_d      = t1_q;
    frc_d     = frc_q;
    d_d       = d_q;
    err_d     = err_q;
    ready_n_d = ready_n_q;

    div_start_n = 1'b1;
    div_a       = '0;
    div_b       = '0;
    div_m       = '0;

    // Euclid update of t: t0 - q*t1, wrapping modulo 2^TWIDTH.
    t_new = t0_q - div_prod;
    // A negative t0 is folded into [0, L); only the low WIDTH bits matter.
    d_fix = t0_q[TWIDTH-1] ? (t0_q[WIDTH-1:0] + l_q) : t0_q[WIDTH-1:0];

    if (!start_n) begin
      state_d   = LOAD;
      e_d       = E;
      l_d       = L;
      err_d     = OFF;
      ready_n_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        LOAD: begin
          r0_d  = l_q;
          r1_d  = e_q;
          t0_d  = '0;
          t1_d  = TWIDTH'(1);
          frc_d = (e_q == '0) || (l_q == '0);
          if ((e_q == '0) || (l_q == '0)) begin
            state_d = FIX;
          end else begin
            state_d     = DIV;
            div_start_n = 1'b0;
            div_a       = l_q;
            div_b       = e_q;
            div_m       = TWIDTH'(1);
          end
        end
        DIV: begin
          if (!div_ready_n) state_d = UPDATE;
        end
        UPDATE: begin
          r0_d = r1_q;
          r1_d = div_rem;
          t0_d = t1_q;
          t1_d = t_new;
          if (div_rem == '0) begin
            state_d = FIX;
          end else begin
            // Next division is issued with the freshly computed r/t values.
            state_d     = DIV;
            div_start_n = 1'b0;
            div_a       = r1_q;
            div_b       = div_rem;
            div_m       = t_new;
          end
        end
        FIX: begin
          if ((r0_q != WIDTH'(1)) || frc_q) begin
            d_d   = '0;
            err_d = ON;
          end else begin
            d_d   = d_fix;
            err_d = OFF;
          end
          ready_n_d = 1'b0;
          state_d   = DONE;
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      e_q       <= '0;
      l_q       <= '0;
      r0_q      <= '0;
      r1_q      <= '0;
      t0_q      <= '0;
      t1_q      <= '0;
      frc_q     <= OFF;
      d_q       <= '0;
      err_q     <= OFF;
      ready_n_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      e_q       <= e_d;
      l_q       <= l_d;
      r0_q      <= r0_d;
      r1_q      <= r1_d;
      t0_q      <= t0_d;
      t1_q      <= t1_d;
      frc_q     <= frc_d;
      d_q       <= d_d;
      err_q     <= err_d;
      ready_n_q <= ready_n_d;
    end
  end

  assign D       = d_q;
  assign err     = err_q;
  assign ready_n = ready_n_q;

endmodule

// File: doc/create_d.md
CREATE_D -- requirements
Module: create_d

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock.
REQ-002 SHALL have port rst_n, input, 1; reset is rst_n, synchronous, active-low; clock is clk.
REQ-003 SHALL have port start_n, input, 1, active-low request; sampled at clk edge; starts or restarts computation.
REQ-004 SHALL have port E, input, 64, public exponent; unsigned.
REQ-005 SHALL have port L, input, 64, modulus (p-1)(q-1); unsigned.
REQ-006 SHALL have port D, output reg, 64, private exponent; D*E = 1 mod L when valid.
REQ-007 SHALL have port err, output reg, 1; 1 = gcd(E,L) != 1, E==0 or L==0.
REQ-008 SHALL have port ready_n, output reg, 1, active-low; 0 = D/err valid.

Function
REQ-009 SHALL implement extended Euclid: r0=L, r1=E, t0=0, t1=1; per iteration q=r0/r1, (r0,r1)=(r1,r0-q*r1), (t0,t1)=(t1,t0-q*t1); stop when r1==0.
REQ-010 SHALL use states IDLE, LOAD, DIV, UPDATE, FIX, DONE; one-hot or encoded is free.
REQ-011 SHALL latch E and L in the cycle start_n is sampled low; later E/L changes are ignored until the next start.
REQ-012 SHALL treat start_n low in any state, including DIV/UPDATE, as an abort+restart: next state LOAD, ready_n=1, err=0.
REQ-013 LOAD (1 cycle): init r0,r1,t0,t1; if E==0 or L==0, go FIX with err forced; if r1==0, go FIX; else go DIV.
REQ-014 DIV: exactly 64 cycles of restoring shift-subtract, one quotient bit per cycle, MSB first.
REQ-015 DIV: accumulate prod=(prod<<1)+(qbit ? t1 : 0) in parallel, so prod=q*t1 at DIV end; no hardware multiplier.
REQ-016 UPDATE (1 cycle): apply REQ-009 update; if new r1==0, go FIX; else go DIV.
REQ-017 t values SHALL be 65-bit two's complement; intermediate wrap modulo 2^65 is permitted (final |t| <= L).
REQ-018 FIX (1 cycle): if r0 != 1 or err forced, D=0 and err=1; else D = t0<0 ? t0+L : t0, err=0.
REQ-019 SHALL give D=0 and err=0 for L==1, since gcd==1 and inverse is 0.
REQ-020 SHALL handle E>=L without pre-reduction: first iteration yields q=0 (E>L) or q=1 (E==L, which gives err=1).
REQ-021 DONE: ready_n=0; D and err held stable; remain in DONE until start_n low or reset.
REQ-022 ready_n SHALL be 1 from the cycle after start_n sampled low until DONE entry.
REQ-023 Latency, start sample to ready_n=0, SHALL be 1 (LOAD) + 65*k + 1 (FIX) + 1 cycles, where k = Euclid iteration count.
REQ-024 D and err SHALL keep their previous values while busy; they update only in FIX.

Reset
REQ-025 rst_n=0 at clk edge: state IDLE, D=0, err=0, ready_n=1, internal registers 0.
REQ-026 rst_n SHALL take priority over start_n; reset mid-computation discards all progress.
REQ-027 After reset, stay in IDLE with ready_n=1 until start_n is sampled low.

Structure
REQ-028 A shared package/header SHALL hold WIDTH=64, TWIDTH=65, state encodings and ON/OFF constants, shared with create_e.
REQ-029 Sub-module divmul64 SHALL hold the 64-cycle divide+q*t accumulator.
REQ-030 divmul64 SHALL use start_n/ready_n handshake and return quotient, remainder, product.
REQ-031 create_d SHALL hold only the FSM, the r/t registers and FIX logic.

Verification
REQ-032 E=17, L=3120, start -> ready_n=0, D=2753, err=0; latency matches REQ-023.
REQ-033 E=3, L=20 -> D=7, err=0; then E=4, L=20 -> D=0, err=1.
REQ-034 E=3, L=0xFFFFFFFFFFFFFFFE -> D=0x5555555555555555, err=0 (exercises full width and negative-t fix).
REQ-035 E=0, L=20 -> err=1, D=0; E=5, L=1 -> D=0, err=0; E=20, L=20 -> err=1.
REQ-036 Abort case: start E=17/L=3120, reassert start_n mid-DIV with E=3/L=20 -> only D=7 reported.
REQ-037 Reset case: rst_n low mid-DIV -> D=0, err=0, ready_n=1, IDLE next cycle.
REQ-038 Random case: 1000 coprime E/L pairs checked against a reference model; D*E mod L == 1.
